mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 The block SHALL have these ports: reset, input, 1, synchronous active-low reset (asserted when 0, sampled on rising clk).
REQ-003 The block SHALL have these ports: mult_start, input, 1, one-cycle request for signed multiply.
REQ-004 The block SHALL have these ports: div_start, input, 1, one-cycle request for signed divide.
REQ-005 The block SHALL have these ports: op_a, input, 32, rs operand (multiplicand or dividend).
REQ-006 The block SHALL have these ports: op_b, input, 32, rt operand (multiplier or divisor).
REQ-007 The block SHALL have these ports: hi, output, 32, product[63:32] or remainder.
REQ-008 The block SHALL have these ports: lo, output, 32, product[31:0] or quotient.
REQ-009 The block SHALL have these ports: mult_done, output, 1, one-cycle multiply-complete pulse.
REQ-010 The block SHALL have these ports: div_done, output, 1, one-cycle divide-complete pulse.
REQ-011 The block SHALL have these ports: busy, output, 1, high from the cycle after start acceptance until the cycle after done.
REQ-012 The block SHALL have these ports: div_by_zero, output, 1, divisor-zero flag, valid with div_done.

Function
REQ-013 The FSM SHALL have states IDLE, MULT_RUN, DIV_RUN and DONE.
REQ-014 In IDLE, mult_start=1 SHALL latch op_a/op_b, clear the 6-bit iteration counter and move to MULT_RUN.
REQ-015 In IDLE, div_start=1 with mult_start=0 SHALL latch operands and move to DIV_RUN.
REQ-016 Simultaneous mult_start and div_start in IDLE SHALL start a multiply, and div_start SHALL be ignored.
REQ-017 A start pulse outside IDLE SHALL be ignored, with no effect on the operation in progress.
REQ-018 MULT_RUN SHALL perform one shift-add step per cycle for 32 cycles on operand magnitudes, then go to DONE.
REQ-019 The multiply SHALL apply sign correction so that {hi,lo} equals the signed 64-bit product op_a*op_b.
REQ-020 DIV_RUN SHALL perform one restoring-division step per cycle for 32 cycles on magnitudes, then go to DONE.
REQ-021 Division SHALL truncate the quotient toward zero, give lo=quotient and hi=remainder, with the remainder taking the sign of the dividend.
REQ-022 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0.
REQ-023 DONE SHALL last exactly one cycle, assert mult_done or div_done for the operation just finished, and then return to IDLE.
REQ-024 hi and lo SHALL update on the edge entering DONE, be valid during the done cycle, and hold until the next completion or reset.
REQ-025 Latency SHALL be 33 cycles: a start sampled on edge N gives done high in the cycle following edge N+33.
REQ-026 A start SHALL be accepted in the cycle immediately after DONE, so back-to-back operations are legal.
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 While reset=0 at a rising edge, the block SHALL set state to IDLE, clear counter, hi, lo and latched operands to 0, and drive mult_done, div_done, busy and div_by_zero to 0.
REQ-029 A reset during MULT_RUN or DIV_RUN SHALL abort the operation, and no done pulse SHALL follow.
REQ-030 While reset=0, start inputs SHALL be ignored.

Configuration
REQ-031 With MULT_DIV_DIVZERO_EN defined, div_start with op_b=0 SHALL skip DIV_RUN and go directly to DONE.
REQ-032 With MULT_DIV_DIVZERO_EN defined and op_b=0, div_done SHALL be high the cycle after acceptance with div_by_zero=1, hi=op_a and lo=0xFFFFFFFF.
REQ-033 With MULT_DIV_DIVZERO_EN defined, div_by_zero SHALL be 0 at all times except during a divide-by-zero done cycle.
REQ-034 Without MULT_DIV_DIVZERO_EN, div_by_zero SHALL be tied to 0 and divide by zero SHALL run the full 33-cycle latency with unspecified hi/lo values.

Verification
REQ-035 The bench SHALL cover: mult_start, op_a=0xFFFFFFFD (-3), op_b=7 -> mult_done 33 cycles later with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-036 The bench SHALL cover: div_start, op_a=-7, op_b=2 -> div_done at 33 cycles with lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 The bench SHALL cover: mult_start and div_start together, op_a=0x10000, op_b=0x10000 -> only mult_done, with hi=1, lo=0.
REQ-038 The bench SHALL cover: reset=0 held one edge at cycle 10 of a divide -> busy=0 and hi=lo=0, with no div_done in the following 40 cycles.
REQ-039 The bench SHALL cover, with MULT_DIV_DIVZERO_EN defined: div_start, op_a=5, op_b=0 -> next cycle div_done=1, div_by_zero=1, hi=5, lo=0xFFFFFFFF.
REQ-040 The bench SHALL cover: a second mult_start issued in the cycle after mult_done, op_a=0x80000000, op_b=0x80000000 -> hi=0x40000000, lo=0.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Request/response bundle for mult_div_unit: start strobes, operands, results and status.
interface mult_div_unit_if;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mult_done;
    logic        div_done;
    logic        busy;
    logic        div_by_zero;

    modport master (
        output mult_start, div_start, op_a, op_b,
        input  hi, lo, mult_done, div_done, busy, div_by_zero
    );

    modport slave (
        input  mult_start, div_start, op_a, op_b,
        output hi, lo, mult_done, div_done, busy, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (shift-add) and divide (restoring), 33-cycle latency.
// Define MULT_DIV_DIVZERO_EN to short-circuit divide-by-zero to a one-cycle result with a flag.
module mult_div_unit (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StMultRun, StDivRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] mag_q, mag_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        neg_a_q, neg_a_d;
    logic        neg_b_q, neg_b_d;
    logic        is_div_q, is_div_d;
`ifdef MULT_DIV_DIVZERO_EN
    logic        dz_q, dz_d;
`endif

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] prod;

    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (32'd0 - x) : x;
    endfunction

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_q} : 33'd0);
    // Partial remainder stays below the divisor magnitude, so bit 32 only matters for the compare.
    assign div_shift = {acc_hi_q, acc_lo_q[31]};
    assign div_ge    = div_shift >= {1'b0, mag_q};
    assign div_rem   = div_shift[31:0] - mag_q;
    assign prod      = {acc_hi_q, acc_lo_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mag_d    = mag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        is_div_d = is_div_q;
`ifdef MULT_DIV_DIVZERO_EN
        dz_d     = dz_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.mult_start || bus.div_start) begin
                    neg_a_d  = bus.op_a[31];
                    neg_b_d  = bus.op_b[31];
                    cnt_d    = 6'd0;
                    acc_hi_d = 32'd0;
                    is_div_d = !bus.mult_start;
`ifdef MULT_DIV_DIVZERO_EN
                    dz_d     = 1'b0;
`endif
                    if (bus.mult_start) begin
                        acc_lo_d = abs32(bus.op_b);
                        mag_d    = abs32(bus.op_a);
                        state_d  = StMultRun;
                    end else begin
                        acc_lo_d = abs32(bus.op_a);
                        mag_d    = abs32(bus.op_b);
                        state_d  = StDivRun;
`ifdef MULT_DIV_DIVZERO_EN
                        if (bus.op_b == 32'd0) begin
                            hi_d    = bus.op_a;
                            lo_d    = 32'hFFFF_FFFF;
                            dz_d    = 1'b1;
                            state_d = StDone;
                        end
`endif
                    end
                end
            end
            StMultRun: begin
                // 32 step cycles, then one cycle for sign correction into hi/lo.
                if (cnt_q == 6'd32) begin
                    {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? (64'd0 - prod) : prod;
                    state_d      = StDone;
                end else begin
                    acc_hi_d = mul_sum[32:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
                    cnt_d    = cnt_q + 6'd1;
                end
            end
            StDivRun: begin
                if (cnt_q == 6'd32) begin
                    lo_d    = (neg_a_q ^ neg_b_q) ? (32'd0 - acc_lo_q) : acc_lo_q;
                    hi_d    = neg_a_q ? (32'd0 - acc_hi_q) : acc_hi_q;
                    state_d = StDone;
                end else begin
                    acc_hi_d = div_ge ? div_rem : div_shift[31:0];
                    acc_lo_d = {acc_lo_q[30:0], div_ge};
                    cnt_d    = cnt_q + 6'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 6'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            mag_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            is_div_q <= 1'b0;
`ifdef MULT_DIV_DIVZERO_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mag_q    <= mag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            is_div_q <= is_div_d;
`ifdef MULT_DIV_DIVZERO_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.mult_done = (state_q == StDone) && !is_div_q;
    assign bus.div_done  = (state_q == StDone) && is_div_q;
`ifdef MULT_DIV_DIVZERO_EN
    assign bus.div_by_zero = (state_q == StDone) && dz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus multi-cycle corner sequences,
// results checked through a scoreboard queue as done pulses appear.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          is_div;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        bit          is_div;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
        bit          chk;
        int          lat;
        int          exp_cyc;
    } sb_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    sb_t  sb[$];
    vec_t vecs[$];

    mult_div_unit_if bus();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit d,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa = longint'($signed(a));
        longint sb_v = longint'($signed(b));
        logic [63:0] p;
        if (!d) begin
            p  = sa * sb_v;
            hi = p[63:32];
            lo = p[31:0];
        end else begin
            p  = sa / sb_v;
            lo = p[31:0];
            p  = sa % sb_v;
            hi = p[31:0];
        end
    endfunction

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input bit d,
                                input logic [31:0] hi, input logic [31:0] lo);
        vec_t v;
        v.a = a; v.b = b; v.is_div = d; v.hi = hi; v.lo = lo;
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        sb_t e;
        if (bus.mult_done || bus.div_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", {62'd0, bus.mult_done, bus.div_done}, 64'd0);
            end else begin
                e = sb.pop_front();
                check("mult_done", {63'd0, bus.mult_done}, {63'd0, !e.is_div});
                check("div_done", {63'd0, bus.div_done}, {63'd0, e.is_div});
                check("latency", 64'(cyc), 64'(e.exp_cyc));
                check("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, e.dz});
                if (e.chk) begin
                    check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
                    check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
                end
            end
        end
    end

    task automatic start_op(input bit m, input bit d, input logic [31:0] a,
                            input logic [31:0] b, input bit push, input sb_t e);
        @(negedge clk);
        bus.mult_start = m;
        bus.div_start  = d;
        bus.op_a       = a;
        bus.op_b       = b;
        if (push) begin
            e.exp_cyc = cyc + e.lat;
            sb.push_back(e);
        end
        @(negedge clk);
        if (push) check("busy_after_start", {63'd0, bus.busy}, 64'd1);
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) return;
        end
        check("done_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    function automatic sb_t exp_of(input bit d, input logic [31:0] hi, input logic [31:0] lo);
        sb_t e;
        e.is_div = d; e.hi = hi; e.lo = lo; e.dz = 1'b0; e.chk = 1'b1; e.lat = 34; e.exp_cyc = 0;
        return e;
    endfunction

    initial begin
        logic [31:0] a, b, h, l;
        sb_t e;
        int  base;

        reset = 1'b0;
        bus.mult_start = 1'b0;
        bus.div_start  = 1'b0;
        bus.op_a = 32'd0;
        bus.op_b = 32'd0;

        vecs.push_back(mk(32'hFFFF_FFFD, 32'd7, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB));
        vecs.push_back(mk(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
        vecs.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000));
        vecs.push_back(mk(32'd100, 32'd7, 1'b1, 32'd2, 32'd14));
        vecs.push_back(mk(32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD));
        vecs.push_back(mk(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'h3FFF_FFFF, 32'h0000_0001));
        vecs.push_back(mk(32'd0, 32'd12345, 1'b0, 32'd0, 32'd0));
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            model(a, b, 1'b0, h, l);
            vecs.push_back(mk(a, b, 1'b0, h, l));
            b = $urandom_range(1, 70000);
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            model(a, b, 1'b1, h, l);
            vecs.push_back(mk(a, b, 1'b1, h, l));
        end

        repeat (3) @(negedge clk);
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {62'd0, bus.mult_done, bus.div_done}, 64'd0);
        check("rst_dz", {63'd0, bus.div_by_zero}, 64'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            start_op(!vecs[i].is_div, vecs[i].is_div, vecs[i].a, vecs[i].b, 1'b1,
                     exp_of(vecs[i].is_div, vecs[i].hi, vecs[i].lo));
            wait_done();
            @(negedge clk);
            check("busy_after_done", {63'd0, bus.busy}, 64'd0);
        end

        // Both strobes together: multiply wins.
        start_op(1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1, exp_of(1'b0, 32'd1, 32'd0));
        wait_done();

        // Strobes mid-operation must not disturb the running multiply.
        start_op(1'b1, 1'b0, 32'd6, 32'd7, 1'b1, exp_of(1'b0, 32'd0, 32'd42));
        repeat (5) @(negedge clk);
        start_op(1'b1, 1'b1, 32'd99, 32'd3, 1'b0, e);
        wait_done();

        // Back-to-back: second start in the cycle right after mult_done.
        start_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd7, 1'b1, exp_of(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB));
        wait_done();
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1,
                 exp_of(1'b0, 32'h4000_0000, 32'd0));
        wait_done();

        // Divide by zero.
        e = exp_of(1'b1, 32'd5, 32'hFFFF_FFFF);
`ifdef MULT_DIV_DIVZERO_EN
        e.dz  = 1'b1;
        e.lat = 1;
`else
        e.chk = 1'b0;
`endif
        start_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b1, e);
        wait_done();
        @(negedge clk);
        check("dz_low_after", {63'd0, bus.div_by_zero}, 64'd0);

        // Reset in the middle of a divide aborts it.
        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, exp_of(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_hi", {32'd0, bus.hi}, 64'd0);
        check("abort_lo", {32'd0, bus.lo}, 64'd0);
        reset = 1'b1;
        sb.delete();
        base = done_cnt;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", 64'(done_cnt), 64'(base));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
